// File: rtl/icache_sched_pkg.sv
// Shared types for the i-cache request scheduler: output-stage state and counter sizing.
package icache_sched_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_t;

    // Width of a counter that must be able to hold the value max_wait.
    function automatic int wait_cnt_width(input int max_wait);
        return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/icache_rr_pick.sv
// Rotate-priority picker: first asserted request at ptr, ptr+1, ... (mod N).
// Purely combinational, zero latency; no flow control of its own.
module icache_rr_pick #(
    parameter int N = 8
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         onehot,
    output logic [$clog2(N)-1:0] idx,
    output logic                 vld
);
    localparam int W = $clog2(N);

    logic         found;
    logic [W-1:0] cand;

    // N is a power of two, so the W-bit sum wraps modulo N for free.
    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 0; k < N; k++) begin
            cand = ptr + W'(k);
            if (!found && req[cand]) begin
                found        = 1'b1;
                idx          = cand;
                onehot[cand] = 1'b1;
            end
        end
    end

    assign vld = |req;

endmodule

// File: rtl/icache_rr_req_sched.sv
// Round-robin i-cache fetch scheduler with starvation override; 1-entry output register, 1 cycle latency,
// refills in the cycle it drains when grant_i is high. Define ICACHE_SCHED_BYPASS_EN for a 0-latency combinational path.
module icache_rr_req_sched
    import icache_sched_pkg::*;
#(
    parameter int N_CORES       = 8,
    parameter int ADDRESS_WIDTH = 32,
    parameter int UID_WIDTH     = 8,
    parameter int MAX_WAIT      = 15
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [N_CORES-1:0]                    request_i,
    input  logic [N_CORES-1:0][ADDRESS_WIDTH-1:0] address_i,
    input  logic [N_CORES-1:0][UID_WIDTH-1:0]     UID_i,
    output logic [N_CORES-1:0]                    grant_o,
    output logic                                  request_o,
    output logic [ADDRESS_WIDTH-1:0]              address_o,
    output logic [UID_WIDTH-1:0]                  UID_o,
    input  logic                                  grant_i,
    output logic                                  starve_o
);
    localparam int                PTR_W    = $clog2(N_CORES);
    localparam int                WAIT_W   = wait_cnt_width(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT);

    logic [PTR_W-1:0]               rr_ptr;
    logic [N_CORES-1:0][WAIT_W-1:0] wait_q;

    logic [N_CORES-1:0] rr_onehot;
    logic [PTR_W-1:0]   rr_idx;
    logic               rr_vld;
    logic [N_CORES-1:0] starve_onehot;
    logic [PTR_W-1:0]   starve_idx;
    logic               starve_sel;
    logic [N_CORES-1:0] win_onehot;
    logic [PTR_W-1:0]   win_idx;
    logic               grant_en;
    logic               up_xfer;

    icache_rr_pick #(
        .N (N_CORES)
    ) u_pick (
        .req    (request_i),
        .ptr    (rr_ptr),
        .onehot (rr_onehot),
        .idx    (rr_idx),
        .vld    (rr_vld)
    );

    // Descending scan so the lowest saturated requester is the one left selected.
    always_comb begin
        starve_onehot = '0;
        starve_idx    = '0;
        starve_sel    = 1'b0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            if (request_i[i] && (wait_q[i] == WAIT_SAT)) begin
                starve_sel       = 1'b1;
                starve_idx       = PTR_W'(i);
                starve_onehot    = '0;
                starve_onehot[i] = 1'b1;
            end
        end
    end

    assign win_onehot = starve_sel ? starve_onehot : rr_onehot;
    assign win_idx    = starve_sel ? starve_idx : rr_idx;
    assign starve_o   = starve_sel;
    assign grant_o    = (grant_en && rr_vld) ? win_onehot : '0;
    assign up_xfer    = |grant_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr <= '0;
            wait_q <= '0;
        end else begin
            if (up_xfer) begin
                rr_ptr <= win_idx + PTR_W'(1);
            end
            for (int i = 0; i < N_CORES; i++) begin
                if (!request_i[i] || grant_o[i]) begin
                    wait_q[i] <= '0;
                end else if (wait_q[i] != WAIT_SAT) begin
                    wait_q[i] <= wait_q[i] + WAIT_W'(1);
                end
            end
        end
    end

`ifdef ICACHE_SCHED_BYPASS_EN
    // Upstream and downstream handshakes coincide; outputs are forced quiet while in reset.
    assign grant_en  = rst_ni & grant_i;
    assign request_o = rst_ni & rr_vld;
    assign address_o = request_o ? address_i[win_idx] : '0;
    assign UID_o     = request_o ? UID_i[win_idx] : '0;
`else
    stage_state_t             state;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [UID_WIDTH-1:0]     uid_q;

    assign grant_en = rst_ni & ((state == ST_EMPTY) | grant_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= ST_EMPTY;
            addr_q <= '0;
            uid_q  <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (up_xfer) begin
                        state  <= ST_FULL;
                        addr_q <= address_i[win_idx];
                        uid_q  <= UID_i[win_idx];
                    end
                end
                ST_FULL: begin
                    // Drain and refill in the same cycle keeps the bank fed back-to-back.
                    if (grant_i) begin
                        if (up_xfer) begin
                            addr_q <= address_i[win_idx];
                            uid_q  <= UID_i[win_idx];
                        end else begin
                            state <= ST_EMPTY;
                        end
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

    assign request_o = (state == ST_FULL);
    assign address_o = addr_q;
    assign UID_o     = uid_q;
`endif

endmodule

// File: tb/tb_icache_rr_req_sched.sv
// Bench for icache_rr_req_sched: directed scenarios plus randomized traffic against a transaction-level model.
module tb_icache_rr_req_sched;
    localparam int NC   = 8;
    localparam int AW   = 32;
    localparam int UW   = 8;
    localparam int MAXW = 15;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NC-1:0]          req_in;
    logic [NC-1:0][AW-1:0]  addr_in;
    logic [NC-1:0][UW-1:0]  uid_in;
    logic [NC-1:0]          gnt_out;
    logic                   req_out;
    logic [AW-1:0]          addr_out;
    logic [UW-1:0]          uid_out;
    logic                   gnt_in;
    logic                   starve_out;

    int checks   = 0;
    int failures = 0;

    // Core-side stimulus state
    bit            creq  [NC];
    logic [AW-1:0] caddr [NC];
    logic [UW-1:0] cuid  [NC];
    bit            gnt;

    // Reference model state
    int            m_ptr;
    int            m_wait [NC];
    bit            m_full;
    logic [AW-1:0] m_addr;
    logic [UW-1:0] m_uid;
    int            e_win;
    bit            e_starve;
    logic [NC-1:0] e_grant;

    always #5 clk = ~clk;

    icache_rr_req_sched #(
        .N_CORES       (NC),
        .ADDRESS_WIDTH (AW),
        .UID_WIDTH     (UW),
        .MAX_WAIT      (MAXW)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .request_i (req_in),
        .address_i (addr_in),
        .UID_i     (uid_in),
        .grant_o   (gnt_out),
        .request_o (req_out),
        .address_o (addr_out),
        .UID_o     (uid_out),
        .grant_i   (gnt_in),
        .starve_o  (starve_out)
    );

    task automatic drive();
        for (int i = 0; i < NC; i++) begin
            req_in[i]  = creq[i];
            addr_in[i] = caddr[i];
            uid_in[i]  = cuid[i];
        end
        gnt_in = gnt;
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_full = 0;
        m_addr = '0;
        m_uid  = '0;
        for (int i = 0; i < NC; i++) m_wait[i] = 0;
    endtask

    // Winner: lowest saturated waiter, else first requester scanning from the pointer.
    task automatic model_eval();
        e_win    = -1;
        e_starve = 0;
        for (int i = 0; i < NC; i++)
            if (e_win < 0 && creq[i] && m_wait[i] == MAXW) begin
                e_win    = i;
                e_starve = 1;
            end
        for (int k = 0; k < NC; k++)
            if (e_win < 0 && creq[(m_ptr + k) % NC]) e_win = (m_ptr + k) % NC;
        e_grant = '0;
        if (e_win >= 0 && (!m_full || gnt)) e_grant[e_win] = 1'b1;
    endtask

    task automatic model_update();
        for (int i = 0; i < NC; i++) begin
            if (!creq[i] || e_grant[i]) m_wait[i] = 0;
            else if (m_wait[i] < MAXW) m_wait[i]++;
        end
        if (e_grant != '0) m_ptr = (e_win + 1) % NC;
        if (e_grant != '0 && (!m_full || gnt)) begin
            m_full = 1;
            m_addr = caddr[e_win];
            m_uid  = cuid[e_win];
        end else if (m_full && gnt) begin
            m_full = 0;
        end
        for (int i = 0; i < NC; i++) if (e_grant[i]) creq[i] = 0;
    endtask

    task automatic set_inputs();
        drive();
        #1;
        model_eval();
    endtask

    task automatic step();
        model_eval();
        model_update();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        #1;
        model_eval();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        gnt   = 0;
        for (int i = 0; i < NC; i++) begin
            creq[i]  = 0;
            caddr[i] = '0;
            cuid[i]  = '0;
        end
        model_reset();
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        set_inputs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        gnt   = 1;
        for (int i = 0; i < NC; i++) begin
            creq[i]  = 1;
            caddr[i] = AW'(32'hABCD_0000 + i);
            cuid[i]  = UW'(i);
        end
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 5;
        if (gnt_out !== '0) begin failures++; $display("FAIL reset_grant: got %h expected 00", gnt_out); end
        if (req_out !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", req_out); end
        if (starve_out !== 1'b0) begin failures++; $display("FAIL reset_starve: got %b expected 0", starve_out); end
        if (addr_out !== '0) begin failures++; $display("FAIL reset_addr: got %h expected 0", addr_out); end
        if (uid_out !== '0) begin failures++; $display("FAIL reset_uid: got %h expected 0", uid_out); end
    endtask

    task automatic test_rr_all();
        logic [NC-1:0] exp_g;
        do_reset();
        gnt = 1;
        for (int i = 0; i < NC; i++) begin
            creq[i]  = 1;
            caddr[i] = AW'(32'h1000 + i);
            cuid[i]  = UW'(8'hA0 + i);
        end
        set_inputs();
        for (int c = 0; c <= NC; c++) begin
            exp_g = NC'(1) << (c % NC);
            checks += 2;
            if (gnt_out !== exp_g) begin failures++; $display("FAIL rr_all_grant c=%0d: got %h expected %h", c, gnt_out, exp_g); end
            if (req_out !== (c != 0)) begin failures++; $display("FAIL rr_all_req c=%0d: got %b expected %b", c, req_out, c != 0); end
            if (c > 0) begin
                checks += 2;
                if (addr_out !== AW'(32'h1000 + (c - 1) % NC)) begin
                    failures++; $display("FAIL rr_all_addr c=%0d: got %h expected %h", c, addr_out, 32'h1000 + (c - 1) % NC);
                end
                if (uid_out !== UW'(8'hA0 + (c - 1) % NC)) begin
                    failures++; $display("FAIL rr_all_uid c=%0d: got %h expected %h", c, uid_out, 8'hA0 + (c - 1) % NC);
                end
            end
            step();
            for (int i = 0; i < NC; i++) creq[i] = 1;
            set_inputs();
        end
    endtask

    task automatic test_two_cores();
        do_reset();
        gnt      = 1;
        creq[2]  = 1;
        caddr[2] = 32'h2222_0002;
        caddr[5] = 32'h5555_0005;
        set_inputs();
        checks++;
        if (gnt_out !== 8'h04) begin failures++; $display("FAIL two_setup: got %h expected 04", gnt_out); end
        step();
        creq[2] = 1;
        creq[5] = 1;
        set_inputs();
        checks++;
        if (gnt_out !== 8'h20) begin failures++; $display("FAIL two_first: got %h expected 20", gnt_out); end
        step();
        checks += 2;
        if (gnt_out !== 8'h04) begin failures++; $display("FAIL two_second: got %h expected 04", gnt_out); end
        if (addr_out !== 32'h5555_0005) begin failures++; $display("FAIL two_addr: got %h expected 55550005", addr_out); end
        step();
        creq[2] = 1;
        creq[5] = 1;
        set_inputs();
        checks++;
        if (gnt_out !== 8'h20) begin failures++; $display("FAIL two_again: got %h expected 20", gnt_out); end
    endtask

    task automatic test_starvation();
        do_reset();
        gnt      = 0;
        creq[1]  = 1;
        caddr[1] = 32'h1111_0001;
        cuid[1]  = 8'h11;
        set_inputs();
        checks++;
        if (gnt_out !== 8'h02) begin failures++; $display("FAIL starve_setup: got %h expected 02", gnt_out); end
        step();
        creq[4]  = 1;
        caddr[4] = 32'h4444_0004;
        cuid[4]  = 8'h44;
        caddr[3] = 32'h3333_0003;
        cuid[3]  = 8'h33;
        set_inputs();
        for (int k = 0; k < 20; k++) begin
            if (k == 10) begin
                creq[3] = 1;
                set_inputs();
            end
            checks += 4;
            if (req_out !== 1'b1) begin failures++; $display("FAIL stall_req k=%0d: got %b expected 1", k, req_out); end
            if (addr_out !== 32'h1111_0001 || uid_out !== 8'h11) begin
                failures++; $display("FAIL stall_hold k=%0d: got %h/%h expected 11110001/11", k, addr_out, uid_out);
            end
            if (gnt_out !== '0) begin failures++; $display("FAIL stall_grant k=%0d: got %h expected 00", k, gnt_out); end
            if (starve_out !== (k >= MAXW)) begin
                failures++; $display("FAIL stall_starve k=%0d: got %b expected %b", k, starve_out, k >= MAXW);
            end
            step();
        end
        gnt = 1;
        set_inputs();
        checks += 2;
        if (gnt_out !== 8'h10) begin failures++; $display("FAIL starve_win: got %h expected 10", gnt_out); end
        if (starve_out !== 1'b1) begin failures++; $display("FAIL starve_flag: got %b expected 1", starve_out); end
        step();
        checks += 3;
        if (addr_out !== 32'h4444_0004) begin failures++; $display("FAIL starve_addr: got %h expected 44440004", addr_out); end
        if (gnt_out !== 8'h08) begin failures++; $display("FAIL starve_next: got %h expected 08", gnt_out); end
        if (starve_out !== 1'b0) begin failures++; $display("FAIL starve_clear: got %b expected 0", starve_out); end
    endtask

    task automatic test_wrap();
        do_reset();
        gnt     = 1;
        creq[6] = 1;
        set_inputs();
        step();
        creq[7] = 1;
        set_inputs();
        checks++;
        if (gnt_out !== 8'h80) begin failures++; $display("FAIL wrap_core7: got %h expected 80", gnt_out); end
        step();
        creq[0] = 1;
        creq[7] = 1;
        set_inputs();
        checks++;
        if (gnt_out !== 8'h01) begin failures++; $display("FAIL wrap_ptr0: got %h expected 01", gnt_out); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        gnt     = 0;
        creq[5] = 1;
        set_inputs();
        step();
        creq[3] = 1;
        creq[6] = 1;
        set_inputs();
        checks++;
        if (req_out !== 1'b1) begin failures++; $display("FAIL midrst_full: got %b expected 1", req_out); end
        rst_n = 1'b0;
        #1;
        model_reset();
        checks += 3;
        if (req_out !== 1'b0) begin failures++; $display("FAIL midrst_req: got %b expected 0", req_out); end
        if (gnt_out !== '0) begin failures++; $display("FAIL midrst_grant: got %h expected 00", gnt_out); end
        if (addr_out !== '0) begin failures++; $display("FAIL midrst_addr: got %h expected 0", addr_out); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        gnt   = 1;
        set_inputs();
        checks++;
        if (gnt_out !== 8'h08) begin failures++; $display("FAIL midrst_first: got %h expected 08", gnt_out); end
    endtask

    task automatic test_random();
        int thr;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NC; i++)
                if (!creq[i] && $urandom_range(0, 2) == 0) begin
                    creq[i]  = 1;
                    caddr[i] = AW'($urandom);
                    cuid[i]  = UW'($urandom);
                end
            thr = ((cyc / 200) % 2 == 1) ? 12 : 80;
            gnt = ($urandom_range(0, 99) < thr);
            set_inputs();
            checks += 3;
            if (gnt_out !== e_grant) begin failures++; $display("FAIL rand_grant cyc=%0d: got %h expected %h", cyc, gnt_out, e_grant); end
            if (req_out !== m_full) begin failures++; $display("FAIL rand_req cyc=%0d: got %b expected %b", cyc, req_out, m_full); end
            if (starve_out !== e_starve) begin failures++; $display("FAIL rand_starve cyc=%0d: got %b expected %b", cyc, starve_out, e_starve); end
            if (m_full) begin
                checks++;
                if (addr_out !== m_addr || uid_out !== m_uid) begin
                    failures++; $display("FAIL rand_payload cyc=%0d: got %h/%h expected %h/%h", cyc, addr_out, uid_out, m_addr, m_uid);
                end
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_rr_all();
        test_two_cores();
        test_starvation();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
